seq_ones_counter: RTL and testbench

SEQ_ONES_COUNTER -- requirements
Module: seq_ones_counter

---
 rtl/ones_counter_pkg.sv | 24 ++
 rtl/seq_ones_counter_chunk_popcount.sv | 21 ++
 rtl/seq_ones_counter.sv | 139 +++++++++++++
 tb/tb_seq_ones_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ones_counter_pkg.sv
// Shared definitions for the sequential ones counter: FSM encodings and a
// ceil(log2) helper used to size counters and chunk popcount results.
package ones_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_ones_counter_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
module chunk_popcount
  import ones_counter_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]               bits,
  output logic [clog2(CHUNK+1)-1:0]      count
);

  localparam int PC_W = clog2(CHUNK + 1);

  // Sum the individual bits of the slice.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/seq_ones_counter.sv
// Multi-cycle ones counter: a word is accepted, its ones are counted CHUNK
// bits per cycle into a saturating sum, and the result is held until taken.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a word; in_ready=1, out_count shows total
// ST_COUNT | adding one chunk per cycle; N = WIDTH/CHUNK cycles
// ST_DONE  | result valid; held until out_ready, then total <= sum
module seq_ones_counter
  import ones_counter_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             sat
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? clog2(N) : 1;
  localparam int PC_W  = clog2(CHUNK + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   sum;
  logic [CNT_W-1:0]   total;
  logic [PC_W-1:0]    chunk_cnt;
  logic [CNT_W:0]     sum_ext;
  logic               clip;
  logic [CNT_W-1:0]   sum_sat;
  logic               accept;

  chunk_popcount #(
    .CHUNK (CHUNK)
  ) u_chunk_popcount (
    .bits  (shreg[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  // clr wins over a simultaneous accept.
  assign accept = (state == ST_IDLE) && in_valid && !clr;

  // Saturating add of this cycle's chunk count; the carry-out marks a clip.
  always_comb begin
    sum_ext = {1'b0, sum} + (CNT_W + 1)'(chunk_cnt);
    clip    = sum_ext[CNT_W];
    sum_sat = clip ? '1 : sum_ext[CNT_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr returns to idle from anywhere.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (in_valid)         state_nxt = ST_COUNT;
        ST_COUNT: if (idx == IDX_LAST)  state_nxt = ST_DONE;
        ST_DONE:  if (out_ready)        state_nxt = ST_IDLE;
        default:                        state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; outside DONE the stored total is shown.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    out_count = out_valid ? sum : total;
  end

  // Datapath: shift register, chunk index, running sum, total and sticky sat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
      sum   <= '0;
      total <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      idx   <= '0;
      sum   <= '0;
      total <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= in_data;
            idx   <= '0;
            sum   <= acc_mode ? total : '0;
            if (!acc_mode) begin
              sat <= 1'b0;
            end
          end
        end
        ST_COUNT: begin
          sum   <= sum_sat;
          shreg <= shreg >> CHUNK;
          idx   <= idx + 1'b1;
          if (clip) begin
            sat <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            total <= sum;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ones_counter.sv
// Directed bench for seq_ones_counter: a 16-bit-count instance and a 7-bit
// (saturating) instance run in lockstep from the same stimulus.
module tb_seq_ones_counter;

  localparam int N = 8;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [63:0] in_data;
  logic        acc_mode;
  logic        out_ready;

  logic        in_ready,  out_valid,  sat;
  logic [15:0] out_count;
  logic        in_ready7, out_valid7, sat7;
  logic [6:0]  out_count7;

  int n_chk;
  int n_fail;

  seq_ones_counter #(.WIDTH(64), .CHUNK(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_mode(acc_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .sat(sat)
  );

  seq_ones_counter #(.WIDTH(64), .CHUNK(8), .CNT_W(7)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready7), .in_data(in_data),
    .acc_mode(acc_mode), .out_valid(out_valid7), .out_ready(out_ready),
    .out_count(out_count7), .sat(sat7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        acc;
    logic [15:0] cnt;
    logic        sat;
    logic [6:0]  cnt7;
    logic        sat7;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the block idle.
  task automatic accept_word(input string tag, input logic [63:0] d, input logic a);
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_data  = d;
    acc_mode = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    acc_mode = ~a;
  endtask

  // Counts edges after the accepting edge until out_valid, bounded.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(N));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_mode  = 1'b0;
    out_ready = 1'b0;

    //        data                    acc cnt   sat  cnt7 sat7
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 16'd64,  0, 7'd64,  0};
    vecs[1] = '{64'h8000_0000_0000_0001, 0, 16'd2,   0, 7'd2,   0};
    vecs[2] = '{64'h0000_0000_0000_00FF, 1, 16'd10,  0, 7'd10,  0};
    vecs[3] = '{64'h0000_0000_0000_0000, 1, 16'd10,  0, 7'd10,  0};
    vecs[4] = '{64'h0000_0000_0000_0000, 0, 16'd0,   0, 7'd0,   0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 16'd64,  0, 7'd64,  0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 16'd128, 0, 7'd127, 1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 16'd192, 0, 7'd127, 1};
    vecs[8] = '{64'h0000_0000_0000_0F0F, 1, 16'd200, 0, 7'd127, 1};
    vecs[9] = '{64'hAAAA_5555_0000_1234, 0, 16'd21,  0, 7'd21,  0};

    // Reset values hold without any clock edge.
    #2;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_count", 64'(out_count), 64'd0);
    chk("reset sat", 64'(sat), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_count", 64'(out_count), 64'd0);

    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      accept_word(tag, vecs[v].data, vecs[v].acc);
      wait_done(tag);
      chk({tag, " out_count"}, 64'(out_count), 64'(vecs[v].cnt));
      chk({tag, " sat"}, 64'(sat), 64'(vecs[v].sat));
      chk({tag, " out_valid7"}, 64'(out_valid7), 64'd1);
      chk({tag, " out_count7"}, 64'(out_count7), 64'(vecs[v].cnt7));
      chk({tag, " sat7"}, 64'(sat7), 64'(vecs[v].sat7));
      release_result(tag);
      chk({tag, " total"}, 64'(out_count), 64'(vecs[v].cnt));
    end

    // Result held while out_ready stays low; in_valid ignored in DONE.
    accept_word("hold", 64'h0000_0000_0000_0003, 1'b0);
    wait_done("hold");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold out_count", 64'(out_count), 64'd2);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_result("hold");
    chk("hold total", 64'(out_count), 64'd2);

    // clr on the third COUNT edge aborts the operation.
    accept_word("clr", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr in_ready", 64'(in_ready), 64'd1);
    chk("clr out_count", 64'(out_count), 64'd0);
    chk("clr sat", 64'(sat), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("clr out_valid never", 64'(seen), 64'd0);
    end
    accept_word("post-clr", 64'h0000_0000_0000_000F, 1'b1);
    wait_done("post-clr");
    chk("post-clr out_count", 64'(out_count), 64'd4);
    chk("post-clr out_count7", 64'(out_count7), 64'd4);
    release_result("post-clr");

    // clr beats a simultaneous accept.
    in_valid = 1'b1;
    in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    acc_mode = 1'b1;
    clr      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    chk("clr-prio in_ready", 64'(in_ready), 64'd1);
    chk("clr-prio out_count", 64'(out_count), 64'd0);
    accept_word("clr-prio", 64'h0000_0000_0000_F0F0, 1'b1);
    wait_done("clr-prio");
    chk("clr-prio result", 64'(out_count), 64'd8);
    release_result("clr-prio");

    // Asynchronous reset in the middle of COUNT.
    accept_word("arst", 64'h0000_0000_0000_0001, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst count phase out_count", 64'(out_count), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst out_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("arst no result", 64'(seen), 64'd0);
    end
    accept_word("post-arst", 64'h0000_0000_0000_0001, 1'b1);
    wait_done("post-arst");
    chk("post-arst out_count", 64'(out_count), 64'd1);
    release_result("post-arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
